// File: rtl/mem_stage.sv
// Memory stage of a small 8-bit pipeline: EX/MEM and MEM/WB registers around a
// DEPTH x 8 data memory, with stall/flush control and a sticky out-of-range flag.
module mem_stage #(
  parameter int DEPTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       EX_RegWrite,
  input  logic       EX_MemRead,
  input  logic       EX_MemWrite,
  input  logic [7:0] EX_alu_res,
  input  logic [7:0] EX_store_data,
  input  logic [4:0] EX_writereg,
  input  logic       stall,
  input  logic       flush,
  output logic       WB_RegWrite,
  output logic [7:0] WB_wb_data,
  output logic [4:0] WB_writereg,
  output logic       mem_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  function automatic logic in_range(input logic [7:0] a);
    return ({1'b0, a} < 9'(DEPTH));
  endfunction

  logic       rw_p0;
  logic       mr_p0;
  logic       mw_p0;
  logic [7:0] alu_p0;
  logic [7:0] sd_p0;
  logic [4:0] wr_p0;

  logic [7:0] mem [DEPTH];

  logic          addr_ok;
  logic          is_load;
  logic          do_write;
  logic [AW-1:0] addr;
  logic [7:0]    rd_data;
  logic [7:0]    wb_next;

  // EX -> MEM boundary
  always_ff @(posedge clk) begin
    if (!rst) begin
      rw_p0  <= 1'b0;
      mr_p0  <= 1'b0;
      mw_p0  <= 1'b0;
      alu_p0 <= '0;
      sd_p0  <= '0;
      wr_p0  <= '0;
    end else if (!stall) begin
      if (flush) begin
        rw_p0  <= 1'b0;
        mr_p0  <= 1'b0;
        mw_p0  <= 1'b0;
        alu_p0 <= '0;
        sd_p0  <= '0;
        wr_p0  <= '0;
      end else begin
        rw_p0  <= EX_RegWrite;
        mr_p0  <= EX_MemRead;
        mw_p0  <= EX_MemWrite;
        alu_p0 <= EX_alu_res;
        sd_p0  <= EX_store_data;
        wr_p0  <= EX_writereg;
      end
    end
  end

  // A load that is also a store is treated purely as a store.
  always_comb begin
    addr     = alu_p0[AW-1:0];
    addr_ok  = in_range(alu_p0);
    is_load  = mr_p0 & ~mw_p0;
    rd_data  = addr_ok ? mem[addr] : 8'h00;
    wb_next  = is_load ? rd_data : alu_p0;
    do_write = ~stall & mw_p0 & addr_ok;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mem <= '{default: 8'h00};
    end else if (do_write) begin
      mem[addr] <= sd_p0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_err <= 1'b0;
    end else if (!stall && (mr_p0 || mw_p0) && !addr_ok) begin
      mem_err <= 1'b1;
    end
  end

  // MEM -> WB boundary
  always_ff @(posedge clk) begin
    if (!rst) begin
      WB_RegWrite <= 1'b0;
      WB_wb_data  <= '0;
      WB_writereg <= '0;
    end else if (!stall) begin
      WB_RegWrite <= rw_p0 & (wr_p0 != 5'd0);
      WB_wb_data  <= wb_next;
      WB_writereg <= wr_p0;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: stimulus pushes expected WB results tagged
// with the cycle they must appear; a negedge monitor pops and compares.
module tb_mem_stage;

  logic       clk = 1'b0;
  logic       rst;
  logic       EX_RegWrite, EX_MemRead, EX_MemWrite;
  logic [7:0] EX_alu_res, EX_store_data;
  logic [4:0] EX_writereg;
  logic       stall, flush;
  logic       WB_RegWrite;
  logic [7:0] WB_wb_data;
  logic [4:0] WB_writereg;
  logic       mem_err;

  mem_stage #(.DEPTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .EX_RegWrite  (EX_RegWrite),
    .EX_MemRead   (EX_MemRead),
    .EX_MemWrite  (EX_MemWrite),
    .EX_alu_res   (EX_alu_res),
    .EX_store_data(EX_store_data),
    .EX_writereg  (EX_writereg),
    .stall        (stall),
    .flush        (flush),
    .WB_RegWrite  (WB_RegWrite),
    .WB_wb_data   (WB_wb_data),
    .WB_writereg  (WB_writereg),
    .mem_err      (mem_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         due;
    logic       rw;
    logic [7:0] d;
    logic [4:0] wr;
    logic       err;
    string      nm;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   errors = 0;
  int   checks = 0;

  always @(negedge clk) begin
    if (q.size() > 0) begin
      if (q[0].due < cyc) begin
        e = q.pop_front();
        checks++;
        errors++;
        $display("FAIL %s: expected slot at cycle %0d never checked (now %0d)", e.nm, e.due, cyc);
      end else if (q[0].due == cyc) begin
        e = q.pop_front();
        checks++;
        if (WB_RegWrite !== e.rw || WB_wb_data !== e.d || WB_writereg !== e.wr || mem_err !== e.err) begin
          errors++;
          $display("FAIL %s @%0d: got rw=%b data=%h wr=%0d err=%b, want rw=%b data=%h wr=%0d err=%b",
                   e.nm, cyc, WB_RegWrite, WB_wb_data, WB_writereg, mem_err, e.rw, e.d, e.wr, e.err);
        end
      end
    end
  end

  task automatic exp(input int due, input logic rw, input logic [7:0] d,
                     input logic [4:0] wr, input logic err, input string nm);
    exp_t x;
    x.due = due; x.rw = rw; x.d = d; x.wr = wr; x.err = err; x.nm = nm;
    q.push_back(x);
  endtask

  task automatic drv(input logic rw, input logic mr, input logic mw,
                     input logic [7:0] alu, input logic [7:0] sd, input logic [4:0] wr,
                     input logic st = 1'b0, input logic fl = 1'b0);
    EX_RegWrite   = rw;
    EX_MemRead    = mr;
    EX_MemWrite   = mw;
    EX_alu_res    = alu;
    EX_store_data = sd;
    EX_writereg   = wr;
    stall         = st;
    flush         = fl;
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b0; stall = 1'b0; flush = 1'b0;
    EX_RegWrite = 1'b0; EX_MemRead = 1'b0; EX_MemWrite = 1'b0;
    EX_alu_res = '0; EX_store_data = '0; EX_writereg = '0;
    repeat (2) @(posedge clk);
    #2;
    exp(cyc, 0, 8'h00, 0, 0, "reset_state");
    rst = 1'b1;
    exp(cyc + 1, 0, 8'h00, 0, 0, "post_reset_bubble");

    // pass-through, x0 suppression, store/load forwarding through memory
    exp(cyc + 2, 1, 8'h2A, 5, 0, "pass_through");   drv(1, 0, 0, 8'h2A, 8'h00, 5);
    exp(cyc + 2, 0, 8'hFF, 0, 0, "x0_write");       drv(1, 0, 0, 8'hFF, 8'h00, 0);
    exp(cyc + 2, 0, 8'h03, 0, 0, "store_a3");       drv(0, 0, 1, 8'h03, 8'h5C, 0);
    exp(cyc + 2, 1, 8'h5C, 7, 0, "load_a3_b2b");    drv(1, 1, 0, 8'h03, 8'h00, 7);
    exp(cyc + 2, 1, 8'h04, 9, 0, "rd_wr_is_store"); drv(1, 1, 1, 8'h04, 8'h77, 9);
    exp(cyc + 2, 1, 8'h77, 10, 0, "load_a4");       drv(1, 1, 0, 8'h04, 8'h00, 10);
    exp(cyc + 2, 1, 8'h00, 11, 0, "load_unwritten");drv(1, 1, 0, 8'h05, 8'h00, 11);
    exp(cyc + 2, 0, 8'h1F, 0, 0, "store_top");      drv(0, 0, 1, 8'h1F, 8'hA5, 0);
    exp(cyc + 2, 1, 8'hA5, 2, 0, "load_top");       drv(1, 1, 0, 8'h1F, 8'h00, 2);

    // three-cycle stall with a fresh instruction waiting in EX/MEM
    exp(cyc + 2, 1, 8'h10, 11, 0, "pre_stall");     drv(1, 0, 0, 8'h10, 8'h00, 11);
    exp(cyc + 2, 0, 8'h06, 0, 0, "store_a6");       drv(0, 0, 1, 8'h06, 8'h66, 0);
    drv(1, 0, 0, 8'h20, 8'h00, 12);
    for (int i = 0; i < 3; i++) begin
      exp(cyc + 1, 0, 8'h06, 0, 0, "stall_frozen");
      drv(1, 0, 1, 8'hEE, 8'hEE, 13, 1'b1, 1'b0);
    end
    exp(cyc + 1, 1, 8'h20, 12, 0, "after_stall");
    exp(cyc + 2, 1, 8'h66, 14, 0, "load_a6");       drv(1, 1, 0, 8'h06, 8'h00, 14);

    // flush a store: bubble in its slot, memory untouched
    exp(cyc + 2, 1, 8'h33, 16, 0, "pre_flush");     drv(1, 0, 0, 8'h33, 8'h00, 16);
    exp(cyc + 2, 0, 8'h00, 0, 0, "flushed_store");  drv(1, 0, 1, 8'h07, 8'h77, 1, 1'b0, 1'b1);
    exp(cyc + 2, 1, 8'h00, 15, 0, "load_a7");       drv(1, 1, 0, 8'h07, 8'h00, 15);

    // stall and flush together: stall wins
    exp(cyc + 2, 1, 8'h43, 19, 0, "pre_sf");        drv(1, 0, 0, 8'h43, 8'h00, 19);
    drv(1, 0, 0, 8'h44, 8'h00, 17);
    exp(cyc + 1, 1, 8'h43, 19, 0, "sf_frozen");     drv(1, 0, 0, 8'h55, 8'h00, 18, 1'b1, 1'b1);
    exp(cyc + 1, 1, 8'h44, 17, 0, "sf_kept");
    exp(cyc + 2, 1, 8'h55, 18, 0, "sf_next");       drv(1, 0, 0, 8'h55, 8'h00, 18);

    // boundary address sets the sticky flag; then reset with a store in MEM
    exp(cyc + 2, 1, 8'h00, 22, 1, "load_a32_oor");  drv(1, 1, 0, 8'h20, 8'h00, 22);
    exp(cyc + 2, 0, 8'h01, 0, 1, "store_a1");       drv(0, 0, 1, 8'h01, 8'h11, 0);
    drv(0, 0, 1, 8'h02, 8'h22, 0);
    rst = 1'b0;
    exp(cyc + 1, 0, 8'h00, 0, 0, "reset_mid");      drv(1, 0, 1, 8'hAB, 8'hCD, 3, 1'b1, 1'b1);
    rst = 1'b1;
    exp(cyc + 1, 0, 8'h00, 0, 0, "reset_hold");
    exp(cyc + 2, 1, 8'h00, 20, 0, "load_a1_clr");   drv(1, 1, 0, 8'h01, 8'h00, 20);
    exp(cyc + 2, 1, 8'h00, 21, 0, "load_a2_clr");   drv(1, 1, 0, 8'h02, 8'h00, 21);

    // out-of-range store must not alias onto address 0
    exp(cyc + 2, 0, 8'h00, 0, 0, "store_a0");       drv(0, 0, 1, 8'h00, 8'h3C, 0);
    exp(cyc + 2, 0, 8'h40, 0, 1, "store_a40_oor");  drv(0, 0, 1, 8'h40, 8'h99, 0);
    exp(cyc + 2, 1, 8'h00, 4, 1, "load_a40_oor");   drv(1, 1, 0, 8'h40, 8'h00, 4);
    exp(cyc + 2, 1, 8'h3C, 6, 1, "load_a0");        drv(1, 1, 0, 8'h00, 8'h00, 6);
    exp(cyc + 2, 1, 8'h00, 8, 1, "load_a20_oor");   drv(1, 1, 0, 8'h20, 8'h00, 8);
    exp(cyc + 2, 0, 8'h00, 0, 1, "err_sticky");     drv(0, 0, 0, 8'h00, 8'h00, 0);

    for (int i = 0; i < 10 && q.size() > 0; i++) drv(0, 0, 0, 8'h00, 8'h00, 0);
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expected results still pending, want 0", q.size());
    end
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
